// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep harness.
// Optional truth-table store is enabled with the TT_SWEEP_STORE_EN macro.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE_ST = 2'd1,
    SAMPLE    = 2'd2,
    DONE_ST   = 2'd3
  } state_e;

  // CRC-16-CCITT style feedback taps; the MISR uses the low SIG_W bits.
  localparam int unsigned DEFAULT_POLY = 32'h0000_1021;

  // Number of input vectors swept for an n-input function.
  function automatic int unsigned vec_count(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Harness bus: sweep control, function drive/response and result readout.
// With TT_SWEEP_STORE_EN the truth-table read port is part of the bus.
interface tt_sweep_capture_if #(
  parameter int unsigned N_IN  = 9,
  parameter int unsigned SIG_W = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic [N_IN-1:0]  vec;
  logic             y_in;
  logic [N_IN:0]    onset_cnt;
  logic [SIG_W-1:0] signature;
  logic             sig_valid;
`ifdef TT_SWEEP_STORE_EN
  logic [N_IN-1:0]  tt_raddr;
  logic             tt_rdata;

  // Controller plus function under test.
  modport master (
    output start, y_in, tt_raddr,
    input  busy, done, vec, onset_cnt, signature, sig_valid, tt_rdata
  );

  // The sweep/capture stage itself.
  modport slave (
    input  start, y_in, tt_raddr,
    output busy, done, vec, onset_cnt, signature, sig_valid, tt_rdata
  );
`else
  modport master (
    output start, y_in,
    input  busy, done, vec, onset_cnt, signature, sig_valid
  );

  modport slave (
    input  start, y_in,
    output busy, done, vec, onset_cnt, signature, sig_valid
  );
`endif
endinterface

// File: rtl/misr_lfsr.sv
// Single-input MISR: shifts left, folds the MSB back through POLY and XORs
// the new response bit into bit 0. Shared with sibling harnesses.
module misr_lfsr #(
  parameter int unsigned SIG_W = 16,
  parameter int unsigned POLY  = 32'h0000_1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  localparam logic [SIG_W-1:0] FB = SIG_W'(POLY);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Next signature; clear has priority over compaction.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? FB : '0)
            ^ {{(SIG_W-1){1'b0}}, din};
    end
  end

  // Signature register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/tt_sweep_capture.sv
// Exhaustive truth-table sweep: drives every input vector into a
// combinational function, counts onset minterms and compacts the responses
// into a MISR signature. Optional truth-table RAM under TT_SWEEP_STORE_EN.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 9,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned SIG_W  = 16,
  parameter int unsigned POLY   = DEFAULT_POLY
) (
  input logic               clk,
  input logic               rst,
  tt_sweep_capture_if.slave bus
);

  localparam logic [N_IN-1:0] VEC_LAST    = N_IN'(vec_count(N_IN) - 1);
  localparam int unsigned     CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e           state_q,     state_d;
  logic [N_IN-1:0]  vec_q,       vec_d;
  logic [N_IN:0]    onset_q,     onset_d;
  logic [CNT_W-1:0] settle_q,    settle_d;
  logic             sig_valid_q, sig_valid_d;
  logic             misr_clr;
  logic             misr_en;

  // Next-state and datapath control for the sweep FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave it unassigned and infer a latch.
    state_d     = state_q;
    vec_d       = vec_q;
    onset_d     = onset_q;
    settle_d    = settle_q;
    sig_valid_d = sig_valid_q;
    misr_clr    = 1'b0;
    misr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          vec_d       = '0;
          onset_d     = '0;
          settle_d    = '0;
          sig_valid_d = 1'b0;
          misr_clr    = 1'b1;
          state_d     = (SETTLE == 0) ? SAMPLE : SETTLE_ST;
        end
      end

      SETTLE_ST: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end

      SAMPLE: begin
        misr_en = 1'b1;
        onset_d = onset_q + {{N_IN{1'b0}}, bus.y_in};
        if (vec_q == VEC_LAST) begin
          // Final vector stays on the bus through DONE_ST.
          sig_valid_d = 1'b1;
          state_d     = DONE_ST;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          state_d = (SETTLE == 0) ? SAMPLE : SETTLE_ST;
        end
      end

      DONE_ST: begin
        vec_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      onset_q     <= '0;
      settle_q    <= '0;
      sig_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      onset_q     <= onset_d;
      settle_q    <= settle_d;
      sig_valid_q <= sig_valid_d;
    end
  end

  misr_lfsr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .din (bus.y_in),
    .sig (bus.signature)
  );

  assign bus.busy      = (state_q == SETTLE_ST) || (state_q == SAMPLE);
  assign bus.done      = (state_q == DONE_ST);
  assign bus.vec       = vec_q;
  assign bus.onset_cnt = onset_q;
  assign bus.sig_valid = sig_valid_q;

`ifdef TT_SWEEP_STORE_EN
  localparam int unsigned VEC_CNT = vec_count(N_IN);

  logic tt_mem [VEC_CNT];
  logic tt_rdata_q;

  // Truth-table capture: one bit per vector, written in its SAMPLE cycle.
  // NOTE: the RAM array is deliberately not reset; only the read register
  // is, so the array maps onto a plain memory macro.
  always_ff @(posedge clk) begin
    if (state_q == SAMPLE) tt_mem[vec_q] <= bus.y_in;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) tt_rdata_q <= 1'b0;
    else     tt_rdata_q <= tt_mem[bus.tt_raddr];
  end

  assign bus.tt_rdata = tt_rdata_q;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture: two instances (SETTLE=1 and
// SETTLE=0) swept with directed response functions; a monitor per
// instance pops the expected result whenever done pulses.
module tb_tt_sweep_capture;
  import tt_sweep_pkg::*;

  localparam int N_IN  = 9;
  localparam int SIG_W = 16;

  typedef struct {
    int             onset;
    logic [15:0]    sig;
    longint         done_cyc;
    int             busy_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     mode1 = 0;
  int     mode0 = 0;
  int     busy_cnt1 = 0;
  int     busy_cnt0 = 0;
  exp_t   q1[$];
  exp_t   q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tt_sweep_capture_if #(.N_IN(N_IN), .SIG_W(SIG_W)) bus1 ();
  tt_sweep_capture_if #(.N_IN(N_IN), .SIG_W(SIG_W)) bus0 ();

  tt_sweep_capture #(.N_IN(N_IN), .SETTLE(1), .SIG_W(SIG_W), .POLY(DEFAULT_POLY))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  tt_sweep_capture #(.N_IN(N_IN), .SETTLE(0), .SIG_W(SIG_W), .POLY(DEFAULT_POLY))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Response functions: 0 const0, 1 x0, 2 AND of all, 3 const1, 4 x8.
  function automatic logic f(input int mode, input logic [8:0] v);
    case (mode)
      1:       return v[0];
      2:       return &v;
      3:       return 1'b1;
      4:       return v[8];
      default: return 1'b0;
    endcase
  endfunction

  assign bus1.y_in = f(mode1, bus1.vec);
  assign bus0.y_in = f(mode0, bus0.vec);

  // Reference MISR straight from the signature recurrence.
  function automatic logic [15:0] misr_ref(input int mode);
    logic [15:0] s;
    s = '0;
    for (int v = 0; v < 512; v++)
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, f(mode, 9'(v))};
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue a sweep on one instance and queue its expected outcome.
  task automatic start_sweep(input bit which, input int mode, input int onset,
                             input logic [15:0] sig, input int n_sweeps);
    exp_t e;
    int   per_sweep;
    @(negedge clk);
    per_sweep = which ? 1024 : 512;
    e.onset = onset;
    e.sig   = sig;
    e.busy_cyc = per_sweep;
    for (int k = 0; k < n_sweeps; k++) begin
      // Back-to-back sweeps restart two cycles after done (DONE_ST, IDLE).
      e.done_cyc = cyc + 1 + per_sweep + longint'(k) * (per_sweep + 2);
      if (which) q1.push_back(e); else q0.push_back(e);
    end
    if (which) begin mode1 = mode; bus1.start = 1'b1; end
    else       begin mode0 = mode; bus0.start = 1'b1; end
    @(negedge clk);
    if (n_sweeps == 1) begin
      if (which) bus1.start = 1'b0; else bus0.start = 1'b0;
    end
    check(which ? "start_busy1" : "start_busy0", which ? bus1.busy : bus0.busy, 1);
    check(which ? "start_clr_valid1" : "start_clr_valid0",
          which ? bus1.sig_valid : bus0.sig_valid, 0);
  endtask

  // Bounded wait for all queued results of one instance.
  task automatic wait_empty(input bit which);
    int i;
    for (i = 0; i < 3000; i++) begin
      if ((which ? q1.size() : q0.size()) == 0) break;
      @(negedge clk);
    end
    if ((which ? q1.size() : q0.size()) != 0) begin
      check(which ? "timeout_done1" : "timeout_done0", 1, 0);
      if (which) q1.delete(); else q0.delete();
    end
  endtask

  // Monitor for the SETTLE=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) busy_cnt1 = 0;
    else begin
      if (bus1.busy) busy_cnt1++;
      if (bus1.done) begin
        if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
        else begin
          e = q1.pop_front();
          check("dut1_onset", bus1.onset_cnt, e.onset);
          check("dut1_sig", bus1.signature, e.sig);
          check("dut1_done_cycle", cyc, e.done_cyc);
          check("dut1_busy_cycles", busy_cnt1, e.busy_cyc);
          check("dut1_valid_at_done", bus1.sig_valid, 1);
          check("dut1_vec_final", bus1.vec, 511);
        end
        busy_cnt1 = 0;
      end
    end
  end

  // Monitor for the SETTLE=0 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) busy_cnt0 = 0;
    else begin
      if (bus0.busy) busy_cnt0++;
      if (bus0.done) begin
        if (q0.size() == 0) check("dut0_unexpected_done", 1, 0);
        else begin
          e = q0.pop_front();
          check("dut0_onset", bus0.onset_cnt, e.onset);
          check("dut0_sig", bus0.signature, e.sig);
          check("dut0_done_cycle", cyc, e.done_cyc);
          check("dut0_busy_cycles", busy_cnt0, e.busy_cyc);
        end
        busy_cnt0 = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst = 1'b1;
    bus1.start = 1'b0;
    bus0.start = 1'b0;
`ifdef TT_SWEEP_STORE_EN
    bus1.tt_raddr = '0;
    bus0.tt_raddr = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", bus1.busy, 0);
    check("rst_done", bus1.done, 0);
    check("rst_vec", bus1.vec, 0);
    check("rst_onset", bus1.onset_cnt, 0);
    check("rst_sig", bus1.signature, 0);
    check("rst_valid", bus1.sig_valid, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Constant 0: nothing counted, signature stays zero.
    start_sweep(1'b1, 0, 0, 16'h0000, 1);
    wait_empty(1'b1);
    repeat (5) @(negedge clk);
    check("valid_holds", bus1.sig_valid, 1);
    check("vec_back_to_0", bus1.vec, 0);

    // x0: alternating 0,1 pattern.
    start_sweep(1'b1, 1, 256, misr_ref(1), 1);
    wait_empty(1'b1);
`ifdef TT_SWEEP_STORE_EN
    @(negedge clk);
    bus1.tt_raddr = 9'd5;
    @(negedge clk);
    check("tt_read_5", bus1.tt_rdata, 1);
    bus1.tt_raddr = 9'd6;
    @(negedge clk);
    check("tt_read_6", bus1.tt_rdata, 0);
`endif

    // AND of all inputs: single 1 at vec=511 lands in bit 0 only.
    start_sweep(1'b1, 2, 1, 16'h0001, 1);
    wait_empty(1'b1);

    // Constant 1: full count without wrap.
    start_sweep(1'b1, 3, 512, misr_ref(3), 1);
    wait_empty(1'b1);

    // SETTLE=0 instance, y = x8.
    start_sweep(1'b0, 4, 256, misr_ref(4), 1);
    wait_empty(1'b0);

    // start held high: second sweep follows from the IDLE after DONE_ST.
    start_sweep(1'b0, 4, 256, misr_ref(4), 2);
    repeat (600) @(negedge clk);
    bus0.start = 1'b0;
    wait_empty(1'b0);

    // Mid-sweep start pulses must not restart the sweep.
    start_sweep(1'b1, 2, 1, 16'h0001, 1);
    repeat (8) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (489) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    wait_empty(1'b1);
    repeat (20) @(negedge clk);

    // Reset mid-sweep at vec=100: results discarded, no done pulse.
    @(negedge clk);
    mode1 = 3;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (i = 0; i < 2000 && bus1.vec != 9'd100; i++) @(negedge clk);
    check("reach_vec100", bus1.vec, 100);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", bus1.busy, 0);
    check("midrst_vec", bus1.vec, 0);
    check("midrst_valid", bus1.sig_valid, 0);
    check("midrst_done", bus1.done, 0);
    check("midrst_onset", bus1.onset_cnt, 0);
    check("midrst_sig", bus1.signature, 0);
    rst = 1'b0;
    repeat (1100) @(negedge clk);
    check("post_rst_idle", bus1.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
